// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding and slot constants for the bus demux receiver
package bus_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  localparam int              NUM_SLOTS = 4;
  localparam int              SEL_W     = 2;
  localparam logic [SEL_W-1:0] LAST_SLOT = 2'd3;
endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot cycle counter, ticks on the last cycle of each slot
module slot_timer #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bus_demux_receiver.sv
// rtl/bus_demux_receiver.sv - steps the source mux selects through four slots and
// publishes the four samples together as one frame
module bus_demux_receiver
  import bus_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SLOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             frame_valid,
  output logic             busy
);
  state_t           r_state;
  logic [SEL_W-1:0] r_slot;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
  logic [WIDTH-1:0] r_o0, r_o1, r_o2, r_o3;
  logic             r_frame_valid;
  logic             r_busy;
  logic             w_tick;
  logic             w_timer_clr;
  logic             w_timer_en;

  assign w_timer_clr = (r_state == IDLE);
  assign w_timer_en  = (r_state == SLOT);

  slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .clk (clk),
    .rst (rst),
    .clr (w_timer_clr),
    .en  (w_timer_en),
    .tick(w_tick)
  );

  // r_slot is held at 0 in IDLE, so the selects need no state qualification
  assign s1          = r_slot[1];
  assign s0          = r_slot[0];
  assign o0          = r_o0;
  assign o1          = r_o1;
  assign o2          = r_o2;
  assign o3          = r_o3;
  assign frame_valid = r_frame_valid;
  assign busy        = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_slot        <= '0;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_o0          <= '0;
      r_o1          <= '0;
      r_o2          <= '0;
      r_o3          <= '0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SLOT;
            r_slot  <= '0;
            r_busy  <= 1'b1;
          end
        end
        SLOT: begin
          if (w_tick) begin
            if (r_slot != LAST_SLOT) begin
              case (r_slot)
                2'd0:    r_sh0 <= d;
                2'd1:    r_sh1 <= d;
                default: r_sh2 <= d;
              endcase
              r_slot <= r_slot + 2'd1;
            end else begin
              // all four outputs move on the same edge so no partial frame is visible
              r_o0          <= r_sh0;
              r_o1          <= r_sh1;
              r_o2          <= r_sh2;
              r_o3          <= d;
              r_frame_valid <= 1'b1;
              r_state       <= IDLE;
              r_slot        <= '0;
              r_busy        <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_demux_receiver.sv
// tb/tb_bus_demux_receiver.sv - directed self-checking bench for bus_demux_receiver
module tb_bus_demux_receiver;
  logic       clk;
  logic       rst;
  logic       start;
  logic [0:0] d;
  logic       s1, s0;
  logic [0:0] o0, o1, o2, o3;
  logic       frame_valid;
  logic       busy;
  logic [3:0] r_src;

  int checks = 0;
  int errors = 0;

  bus_demux_receiver #(
    .WIDTH(1),
    .SLOT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .d          (d),
    .s1         (s1),
    .s0         (s0),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .frame_valid(frame_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source mux model: bit n of r_src is source i<n>
  always_comb d = r_src[{s1, s0}];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    r_src = 4'b0000;
    #3;
    checks++;
    if ({o3, o2, o1, o0, frame_valid, busy, s1, s0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got %b want 00000000", {o3, o2, o1, o0, frame_valid, busy, s1, s0});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    logic [1:0] exp_sel;
    r_src = 4'b1010;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) step();
      if (k < 16) begin
        exp_sel = 2'(k / 4);
        checks++;
        if ({s1, s0} !== exp_sel || busy !== 1'b1 || frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_slot k=%0d sel=%b busy=%b fv=%b want sel=%b busy=1 fv=0",
                   k, {s1, s0}, busy, frame_valid, exp_sel);
        end
      end else if (k == 16) begin
        checks++;
        if (frame_valid !== 1'b1 || {o3, o2, o1, o0} !== 4'b1010 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
          errors++;
          $display("FAIL basic_done fv=%b o=%b busy=%b sel=%b want fv=1 o=1010 busy=0 sel=00",
                   frame_valid, {o3, o2, o1, o0}, busy, {s1, s0});
        end
      end else begin
        checks++;
        if (frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_fv_fall got %b want 0", frame_valid);
        end
      end
    end
  endtask

  task automatic test_second_frame();
    int pulses = 0;
    r_src = 4'b0101;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (frame_valid) pulses++;
      if (k == 15) begin
        checks++;
        if ({o3, o2, o1, o0} !== 4'b1010) begin
          errors++;
          $display("FAIL second_hold got %b want 1010", {o3, o2, o1, o0});
        end
      end
      if (k == 16) begin
        checks++;
        if ({o3, o2, o1, o0} !== 4'b0101 || frame_valid !== 1'b1) begin
          errors++;
          $display("FAIL second_done o=%b fv=%b want o=0101 fv=1", {o3, o2, o1, o0}, frame_valid);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL second_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    r_src = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3 || k == 16);
      step();
      start = 1'b0;
      if (frame_valid) pulses++;
      if (k == 4) begin
        checks++;
        if (busy !== 1'b1 || {s1, s0} !== 2'b01) begin
          errors++;
          $display("FAIL ignore_busy busy=%b sel=%b want busy=1 sel=01", busy, {s1, s0});
        end
      end
      if (k == 17 || k == 25) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL ignore_requeue k=%0d busy=%b want 0", k, busy);
        end
      end
    end
    checks++;
    if (pulses != 1 || {o3, o2, o1, o0} !== 4'b0011) begin
      errors++;
      $display("FAIL ignore_pulses pulses=%0d o=%b want pulses=1 o=0011", pulses, {o3, o2, o1, o0});
    end
  endtask

  task automatic test_start_held();
    int first = -1;
    int second = -1;
    r_src = 4'b1001;
    start = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      step();
      if (frame_valid) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    start = 1'b0;
    for (int n = 0; n < 20; n++) step();
    checks++;
    if (first != 16 || second != 33) begin
      errors++;
      $display("FAIL held_spacing first=%0d second=%0d want 16 and 33", first, second);
    end
    checks++;
    if ({o3, o2, o1, o0} !== 4'b1001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_final o=%b busy=%b want o=1001 busy=0", {o3, o2, o1, o0}, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    r_src = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o3, o2, o1, o0} !== 4'b0000 || busy !== 1'b0 || frame_valid !== 1'b0 || {s1, s0} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset o=%b busy=%b fv=%b sel=%b want all 0",
               {o3, o2, o1, o0}, busy, frame_valid, {s1, s0});
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (frame_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort pulses=%0d busy=%b want 0 and 0", pulses, busy);
    end
    r_src = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    checks++;
    if ({o3, o2, o1, o0} !== 4'b0110 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_frame o=%b fv=%b want o=0110 fv=1", {o3, o2, o1, o0}, frame_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_second_frame();
    test_ignore_start();
    test_start_held();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
